multi_debouncer: RTL and testbench
==================================

MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 Parameter: N, default 4, number of independent input channels (1..32).
REQ-002 Parameter: STABLE_CYCLES, default 16, consecutive synchronised-mismatch cycles required before an output changes (2..65535).
REQ-003 Parameter: INIT_LEVEL, default 1'b0, value loaded into every debounced output and synchroniser flop at reset.
REQ-004 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: in  input  N  raw asynchronous inputs (buttons/switches), one bit per channel.
REQ-007 Port: out  output  N  debounced level per channel, registered.
REQ-008 Port: rise  output  N  one-cycle pulse per channel when out goes 0->1.
REQ-009 Port: fall  output  N  one-cycle pulse per channel when out goes 1->0.
REQ-010 Port: busy  output  N  per channel, high while synchronised input differs from out (count in progress).

Function
REQ-011 Each channel SHALL pass in[i] through a 2-flop synchroniser (s1, s2) before any comparison.
REQ-012 Each channel SHALL hold a counter of width $clog2(STABLE_CYCLES), saturating never; it SHALL clear whenever s2 == out[i].
REQ-013 While s2 != out[i] and count < STABLE_CYCLES-1, count SHALL increment by 1 per cycle.
REQ-014 When s2 != out[i] and count == STABLE_CYCLES-1, out[i] SHALL load s2 and count SHALL clear on the same edge.
REQ-015 Latency: in[i] toggled and held, first sampled at edge k -> out[i] changes at edge k+1+STABLE_CYCLES exactly.
REQ-016 Glitch rule: any cycle with s2 == out[i] during counting SHALL restart the count from 0; no partial credit.
REQ-017 rise[i]/fall[i] SHALL be registered, asserted for exactly the one cycle in which the new out[i] value is first visible; never both high.
REQ-018 busy[i] SHALL be combinational (s2 != out[i]).
REQ-019 Channels SHALL be fully independent; simultaneous events on several channels SHALL each be handled per REQ-013..017.

Reset
REQ-020 On rst high: s1, s2, out = {N{INIT_LEVEL}}; all counts = 0; rise = fall = 0; busy therefore 0.
REQ-021 Reset asserted mid-count SHALL discard the count; after release, a held input SHALL need the full 2+STABLE_CYCLES cycles again.
REQ-022 No rise/fall pulse SHALL be generated by reset assertion or release.

Configuration
REQ-023 Macro MULTI_DEBOUNCER_EDGE_EN: when defined, rise/fall logic per REQ-017 is built.
REQ-024 Without MULTI_DEBOUNCER_EDGE_EN, rise and fall SHALL be tied to constant 0 and their registers SHALL not exist; all other behaviour unchanged.

Structure
REQ-025 Shared package debounce_pkg SHALL hold: DEB_SYNC_STAGES = 2, DEB_MIN_STABLE = 2, DEB_MAX_CHANNELS = 32, and function deb_cnt_w(stable) returning counter width.
REQ-026 Per-channel logic SHALL be one sub-module, debounce_channel (sync + counter + out/edge regs), instantiated N times by a generate loop.
REQ-027 Parameter legality (N, STABLE_CYCLES out of range) SHALL be checked at elaboration with a fatal error.

Verification (N=4, STABLE_CYCLES=8, INIT_LEVEL=0, edge enabled unless noted)
REQ-028 Reset: assert rst, in=4'hF -> out=0, rise=fall=busy=0 throughout; release, hold in=4'hF -> out=4'hF exactly 10 cycles after first sampling edge, rise=4'hF for 1 cycle.
REQ-029 Bounce: in[0] toggles 1,0,1,0 every 3 cycles then holds 1 -> out[0] stays 0 until 10 cycles after final rising edge of in[0]; single rise[0] pulse.
REQ-030 Release: out[2]=1, in[2] drops to 0 and holds -> fall[2] one cycle, out[2]=0 after 10 cycles, busy[2] high for the 8 cycles preceding.
REQ-031 Mid-count reset: in[1] held 1 for 6 cycles, rst pulsed 1 cycle, in[1] still 1 -> out[1] rises 10 cycles after rst release, not earlier.
REQ-032 Independence: in=4'b0101 at same edge, in[3] glitches 1 cycle -> out=4'b0101 after 10 cycles, out[3] stays 0, no fall/rise on channel 3.
REQ-033 Build without MULTI_DEBOUNCER_EDGE_EN, repeat REQ-028 -> out identical, rise=fall=0 always.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared limits and counter sizing for the multi-channel debouncer.
package debounce_pkg;
  localparam int DEB_SYNC_STAGES = 2;
  localparam int DEB_MIN_STABLE = 2;
  localparam int DEB_MAX_CHANNELS = 32;
  function automatic int deb_cnt_w(input int stable);
    return $clog2(stable);
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one channel (2-flop sync, mismatch counter, out reg, rise/fall regs under MULTI_DEBOUNCER_EDGE_EN).
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic busy
);
  localparam int CW = deb_cnt_w(STABLE_CYCLES);
  logic s1, s2, done;
  logic [CW-1:0] cnt;
  assign busy = s2 != out;
  assign done = busy && cnt == CW'(STABLE_CYCLES - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= INIT_LEVEL;
      s2 <= INIT_LEVEL;
      out <= INIT_LEVEL;
      cnt <= '0;
    end else begin
      s1 <= in;
      s2 <= s1;
      cnt <= busy && !done ? cnt + CW'(1) : '0;
      if (done) out <= s2;
    end
  end
`ifdef MULTI_DEBOUNCER_EDGE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= done & s2;
      fall <= done & ~s2;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif
endmodule

// File: rtl/multi_debouncer.sv
// multi_debouncer: N independent debounced channels; define MULTI_DEBOUNCER_EDGE_EN to build rise/fall pulses.
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int N = 4,
  parameter int STABLE_CYCLES = 16,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] busy
);
  if (N < 1 || N > DEB_MAX_CHANNELS) begin : g_bad_n
    $fatal(1, "multi_debouncer: N=%0d out of range", N);
  end
  if (STABLE_CYCLES < DEB_MIN_STABLE || STABLE_CYCLES > 65535) begin : g_bad_stable
    $fatal(1, "multi_debouncer: STABLE_CYCLES=%0d out of range", STABLE_CYCLES);
  end
  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .INIT_LEVEL(INIT_LEVEL)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .in(in[i]),
      .out(out[i]),
      .rise(rise[i]),
      .fall(fall[i]),
      .busy(busy[i])
    );
  end
endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: scenario tasks plus a streak-based reference model checked every cycle.
module tb_multi_debouncer;
  localparam int N = 4;
  localparam int S = 8;
`ifdef MULTI_DEBOUNCER_EDGE_EN
  localparam logic EDGE = 1'b1;
`else
  localparam logic EDGE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] in = '0;
  logic [N-1:0] out, rise, fall, busy;
  int checks = 0;
  int errors = 0;

  multi_debouncer #(.N(N), .STABLE_CYCLES(S), .INIT_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .in(in), .out(out), .rise(rise), .fall(fall), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: input seen through a 2-sample history; output flips after S consecutive mismatching cycles.
  logic [N-1:0] hist[$] = '{4'h0, 4'h0};
  logic [N-1:0] m_out = '0, m_rise = '0, m_fall = '0, sy;
  int streak[N];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist = '{4'h0, 4'h0};
      m_out = '0;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < N; i++) streak[i] = 0;
    end else begin
      sy = hist[0];
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < N; i++) begin
        if (sy[i] != m_out[i]) begin
          streak[i] = streak[i] + 1;
          if (streak[i] == S) begin
            m_out[i] = sy[i];
            streak[i] = 0;
            m_rise[i] = sy[i] & EDGE;
            m_fall[i] = ~sy[i] & EDGE;
          end
        end else streak[i] = 0;
      end
      hist.push_back(in);
      void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({out, busy, rise, fall} !== {m_out, hist[0] ^ m_out, m_rise, m_fall}) begin
      errors++;
      $display("FAIL model t=%0t out=%h exp %h busy=%h exp %h rise=%h exp %h fall=%h exp %h",
               $time, out, m_out, busy, hist[0] ^ m_out, rise, m_rise, fall, m_fall);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N-1:0] v);
    rst = 1'b1;
    in = v;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    int n, rc;
    rst = 1'b1;
    in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      cyc(1);
      checks++;
      if ({out, rise, fall, busy} !== '0) begin
        errors++;
        $display("FAIL reset_hold out=%h rise=%h fall=%h busy=%h exp all 0", out, rise, fall, busy);
      end
    end
    rst = 1'b0;
    n = 0;
    rc = 0;
    while (n < 30 && out !== 4'hF) begin
      cyc(1);
      n++;
      if (rise !== 4'h0 && out !== 4'hF) rc++;
    end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL reset_latency got %0d exp 10", n);
    end
    checks++;
    if (rise !== (EDGE ? 4'hF : 4'h0) || rc !== 0) begin
      errors++;
      $display("FAIL reset_rise rise=%h early=%0d exp %h", rise, rc, EDGE ? 4'hF : 4'h0);
    end
    cyc(1);
    checks++;
    if (rise !== 4'h0 || fall !== 4'h0) begin
      errors++;
      $display("FAIL reset_rise_width rise=%h fall=%h exp 0", rise, fall);
    end
  endtask

  task automatic test_bounce;
    int n, rc;
    do_reset('0);
    cyc(3);
    rc = 0;
    for (int b = 0; b < 4; b++) begin
      in[0] = (b % 2 == 0);
      for (int c = 0; c < 3; c++) begin
        cyc(1);
        if (out[0] !== 1'b0) rc++;
      end
    end
    checks++;
    if (rc !== 0) begin
      errors++;
      $display("FAIL bounce_early got %0d high cycles exp 0", rc);
    end
    in[0] = 1'b1;
    n = 0;
    rc = 0;
    while (n < 30 && out[0] !== 1'b1) begin
      cyc(1);
      n++;
      rc += int'(rise[0]);
    end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL bounce_latency got %0d exp 10", n);
    end
    cyc(3);
    rc += int'(rise[0]);
    checks++;
    if (rc !== int'(EDGE)) begin
      errors++;
      $display("FAIL bounce_rise_count got %0d exp %0d", rc, int'(EDGE));
    end
  endtask

  task automatic test_release;
    int n, bc, fc;
    in = 4'b0100;
    n = 0;
    while (n < 30 && out !== 4'b0100) begin
      cyc(1);
      n++;
    end
    cyc(2);
    checks++;
    if (out !== 4'b0100) begin
      errors++;
      $display("FAIL release_setup out=%h exp 4", out);
    end
    in[2] = 1'b0;
    n = 0;
    bc = 0;
    fc = 0;
    while (n < 30 && out[2] !== 1'b0) begin
      cyc(1);
      n++;
      if (out[2] === 1'b1) bc += int'(busy[2]);
      fc += int'(fall[2]);
    end
    cyc(2);
    fc += int'(fall[2]);
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL release_latency got %0d exp 10", n);
    end
    checks++;
    if (bc !== 8) begin
      errors++;
      $display("FAIL release_busy got %0d exp 8", bc);
    end
    checks++;
    if (fc !== int'(EDGE)) begin
      errors++;
      $display("FAIL release_fall_count got %0d exp %0d", fc, int'(EDGE));
    end
  endtask

  task automatic test_mid_reset;
    int n;
    do_reset('0);
    cyc(2);
    in[1] = 1'b1;
    cyc(6);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    n = 0;
    while (n < 30 && out[1] !== 1'b1) begin
      cyc(1);
      n++;
    end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL midreset_latency got %0d exp 10", n);
    end
  endtask

  task automatic test_independence;
    int n, bad;
    do_reset('0);
    cyc(2);
    in = 4'b1101;
    cyc(1);
    in = 4'b0101;
    n = 1;
    bad = 0;
    while (n < 30 && out !== 4'b0101) begin
      cyc(1);
      n++;
      if (out[3] | rise[3] | fall[3]) bad++;
    end
    cyc(12);
    if (out[3] | rise[3] | fall[3]) bad++;
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL indep_latency got %0d exp 10", n);
    end
    checks++;
    if (bad !== 0 || out !== 4'b0101) begin
      errors++;
      $display("FAIL indep_ch3 bad=%0d out=%h exp 0/5", bad, out);
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) in[$urandom_range(0, N - 1)] ^= 1'b1;
      else if ($urandom_range(0, 9) == 0) in = N'($urandom);
      if ($urandom_range(0, 60) == 0) begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end
      cyc($urandom_range(1, 12));
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_release();
    test_mid_reset();
    test_independence();
    test_random();
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
